// File: rtl/avl_stream_if.sv
// Avalon-ST style stream bundle with sop/eop framing and byte-empty field.
interface avl_stream_if #(
  parameter int WIDTH   = 40,
  parameter int EMPTY_W = 2
);
  logic [WIDTH-1:0]   data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport tx (output data, valid, sop, eop, empty, input ready);
  modport rx (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/stats_unpacker_avlstrm.sv
// Unpacks framed {addr,val} stats beats into a CSR-readable register array.
// Optional STATS_UNPACK_COHERENT_EN: shadow array + COMMIT state for atomic frames.
module stats_unpacker_avlstrm #(
  parameter int NUM_REGS   = 64,
  parameter int REG_AWIDTH = 8,
  parameter int VAL_WIDTH  = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  avl_stream_if.rx              in,
  input  logic [REG_AWIDTH-1:0] csr_address,
  input  logic                  csr_read,
  output logic [VAL_WIDTH-1:0]  csr_readdata,
  output logic                  csr_readdatavalid,
  output logic [31:0]           frame_cnt,
  output logic [31:0]           frame_err_cnt,
  output logic [31:0]           addr_err_cnt,
  output logic                  update
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [REG_AWIDTH:0] NUM_REGS_X = (REG_AWIDTH+1)'(NUM_REGS);

`ifdef STATS_UNPACK_COHERENT_EN
  typedef enum logic [1:0] {IDLE, FRAME, COMMIT} state_t;
`else
  typedef enum logic {IDLE, FRAME} state_t;
`endif

  state_t                state;
  logic [VAL_WIDTH-1:0]  vis [NUM_REGS];
  logic [REG_AWIDTH-1:0] beat_addr;
  logic [VAL_WIDTH-1:0]  beat_val;
  logic [IDX_W-1:0]      beat_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  accept, stray, restart, process, in_range, wr_en, end_frame;
  logic                  rd_in_range;
  logic                  unused_empty;

  assign beat_addr    = in.data[REG_AWIDTH+VAL_WIDTH-1:VAL_WIDTH];
  assign beat_val     = in.data[VAL_WIDTH-1:0];
  assign beat_idx     = beat_addr[IDX_W-1:0];
  assign rd_idx       = csr_address[IDX_W-1:0];
  assign unused_empty = ^in.empty;

`ifdef STATS_UNPACK_COHERENT_EN
  assign in.ready = Rst_n && (state != COMMIT);
`else
  assign in.ready = Rst_n;
`endif

  // A sop-less beat outside a frame is dropped; a sop inside a frame restarts it.
  assign accept      = in.valid && in.ready;
  assign stray       = accept && (state == IDLE) && !in.sop;
  assign restart     = accept && (state == FRAME) && in.sop;
  assign process     = accept && !stray;
  assign in_range    = {1'b0, beat_addr} < NUM_REGS_X;
  assign wr_en       = process && in_range;
  assign end_frame   = process && in.eop;
  assign rd_in_range = {1'b0, csr_address} < NUM_REGS_X;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      frame_err_cnt <= '0;
      addr_err_cnt  <= '0;
      update        <= 1'b0;
    end else begin
      update <= 1'b0;
      if (stray || restart)
        frame_err_cnt <= frame_err_cnt + 32'd1;
      if (process && !in_range)
        addr_err_cnt <= addr_err_cnt + 32'd1;
      if (end_frame)
        frame_cnt <= frame_cnt + 32'd1;
`ifdef STATS_UNPACK_COHERENT_EN
      if (state == COMMIT) begin
        state  <= IDLE;
        update <= 1'b1;
      end else if (end_frame) begin
        state <= COMMIT;
      end else if (process) begin
        state <= FRAME;
      end
`else
      update <= wr_en;
      if (end_frame)
        state <= IDLE;
      else if (process)
        state <= FRAME;
`endif
    end
  end

`ifdef STATS_UNPACK_COHERENT_EN
  logic [VAL_WIDTH-1:0] shadow [NUM_REGS];
  logic [NUM_REGS-1:0]  pend;
  logic [NUM_REGS-1:0]  pend_nxt;

  // A restart forgets the abandoned frame's pending entries before marking the new beat.
  always_comb begin
    pend_nxt = restart ? '0 : pend;
    if (wr_en)
      pend_nxt[beat_idx] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        vis[i]    <= '0;
        shadow[i] <= '0;
      end
      pend <= '0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (pend[i])
          vis[i] <= shadow[i];
      pend <= '0;
    end else begin
      if (wr_en)
        shadow[beat_idx] <= beat_val;
      pend <= pend_nxt;
    end
  end
`else
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        vis[i] <= '0;
    end else if (wr_en) begin
      vis[beat_idx] <= beat_val;
    end
  end
`endif

  // CSR read port: one-cycle latency, sees the array as it was before this edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read)
        csr_readdata <= rd_in_range ? vis[rd_idx] : '0;
    end
  end
endmodule

// File: tb/tb_stats_unpacker_avlstrm.sv
// Scoreboard bench for stats_unpacker_avlstrm; honours STATS_UNPACK_COHERENT_EN.
module tb_stats_unpacker_avlstrm;
  localparam int NUM_REGS   = 64;
  localparam int REG_AWIDTH = 8;
  localparam int VAL_WIDTH  = 32;

  logic                  Clk = 1'b0;
  logic                  Rst_n = 1'b0;
  logic [REG_AWIDTH-1:0] csr_address;
  logic                  csr_read;
  logic [VAL_WIDTH-1:0]  csr_readdata;
  logic                  csr_readdatavalid;
  logic [31:0]           frame_cnt, frame_err_cnt, addr_err_cnt;
  logic                  update;

  always #5 Clk = ~Clk;

  avl_stream_if #(.WIDTH(REG_AWIDTH+VAL_WIDTH)) s ();

  stats_unpacker_avlstrm #(
    .NUM_REGS(NUM_REGS), .REG_AWIDTH(REG_AWIDTH), .VAL_WIDTH(VAL_WIDTH)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .in(s),
    .csr_address(csr_address), .csr_read(csr_read),
    .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid),
    .frame_cnt(frame_cnt), .frame_err_cnt(frame_err_cnt),
    .addr_err_cnt(addr_err_cnt), .update(update)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: visible values, open-frame flag, counters, pending commit.
  logic [31:0] m_vis [NUM_REGS];
`ifdef STATS_UNPACK_COHERENT_EN
  logic [31:0] m_shd [NUM_REGS];
  bit          m_pend [NUM_REGS];
`endif
  bit          m_inframe, m_commit, m_upd;
  logic [31:0] m_fcnt, m_ferr, m_aerr;
  logic [31:0] rdq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_vis[i] = 0;
`ifdef STATS_UNPACK_COHERENT_EN
      m_shd[i]  = 0;
      m_pend[i] = 0;
`endif
    end
    m_inframe = 0; m_commit = 0; m_upd = 0;
    m_fcnt = 0; m_ferr = 0; m_aerr = 0;
    rdq.delete();
  endfunction

  // Applies the inputs present at this rising edge to the model.
  function automatic void model_step();
    int unsigned a;
    a = int'(s.data[REG_AWIDTH+VAL_WIDTH-1:VAL_WIDTH]);
    m_upd = 0;
    if (csr_read)
      rdq.push_back((int'(csr_address) < NUM_REGS) ? m_vis[int'(csr_address)] : 32'd0);
    if (m_commit) begin
`ifdef STATS_UNPACK_COHERENT_EN
      for (int i = 0; i < NUM_REGS; i++) begin
        if (m_pend[i]) m_vis[i] = m_shd[i];
        m_pend[i] = 0;
      end
`endif
      m_commit = 0;
      m_upd    = 1;
    end else if (s.valid) begin
      if (!m_inframe && !s.sop) begin
        m_ferr++;
      end else begin
        if (m_inframe && s.sop) begin
          m_ferr++;
`ifdef STATS_UNPACK_COHERENT_EN
          for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 0;
`endif
        end
        if (a < NUM_REGS) begin
`ifdef STATS_UNPACK_COHERENT_EN
          m_shd[a]  = s.data[VAL_WIDTH-1:0];
          m_pend[a] = 1;
`else
          m_vis[a] = s.data[VAL_WIDTH-1:0];
          m_upd    = 1;
`endif
        end else begin
          m_aerr++;
        end
        if (s.eop) begin
          m_fcnt++;
          m_inframe = 0;
`ifdef STATS_UNPACK_COHERENT_EN
          m_commit = 1;
`endif
        end else begin
          m_inframe = 1;
        end
      end
    end
  endfunction

  // Monitor: checks read responses and all status outputs away from the rising edge.
  always @(negedge Clk) begin
    if (csr_readdatavalid) begin
      if (rdq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdv_spurious: got csr_readdatavalid=1 expected 0 at %0t", $time);
      end else begin
        check("csr_readdata", csr_readdata, rdq.pop_front());
      end
    end
    if (rdq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rdv_missing: got csr_readdatavalid=%0b expected 1 at %0t", csr_readdatavalid, $time);
      rdq.delete();
    end
    check("ready", {31'b0, s.ready}, {31'b0, Rst_n && !m_commit});
    check("update", {31'b0, update}, {31'b0, m_upd});
    check("frame_cnt", frame_cnt, m_fcnt);
    check("frame_err_cnt", frame_err_cnt, m_ferr);
    check("addr_err_cnt", addr_err_cnt, m_aerr);
  end

  task automatic step(input bit v, input bit sp, input bit ep, input logic [7:0] a,
                      input logic [31:0] d, input bit rd, input logic [7:0] ra);
    s.valid = v; s.sop = sp; s.eop = ep; s.data = {a, d}; s.empty = '0;
    csr_read = rd; csr_address = ra;
    @(posedge Clk);
    if (Rst_n) model_step();
    #1;
    s.valid = 1'b0; csr_read = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, 32'd0, 0, 8'd0);
  endtask

  task automatic rd(input logic [7:0] ra);
    step(0, 0, 0, 8'd0, 32'd0, 1, ra);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s.valid = 0; s.sop = 0; s.eop = 0; s.data = '0; s.empty = '0;
    csr_read = 0; csr_address = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;

    // Three-beat frame with a repeated address; read 5 in the cycle after eop.
    step(1, 1, 0, 8'd2, 32'h10, 0, 8'd0);
    step(1, 0, 0, 8'd5, 32'h20, 0, 8'd0);
    step(1, 0, 1, 8'd2, 32'h30, 0, 8'd0);
    rd(8'd5);
    rd(8'd5);
    rd(8'd2);
    idle(1);
    check("t1_frame_cnt", frame_cnt, 32'd1);
    check("t1_errs", frame_err_cnt | addr_err_cnt, 32'd0);

    // Missing eop: second sop restarts the frame.
    step(1, 1, 0, 8'd1, 32'h7, 0, 8'd0);
    step(1, 1, 1, 8'd1, 32'h9, 0, 8'd0);
    rd(8'd1);
    rd(8'd1);
    idle(1);
    check("t3_frame_err_cnt", frame_err_cnt, 32'd1);
    check("t3_frame_cnt", frame_cnt, 32'd2);

    // Out-of-range address inside a frame, then read of that address.
    step(1, 1, 0, 8'd3, 32'h33, 0, 8'd0);
    step(1, 0, 0, 8'd70, 32'hdead, 0, 8'd0);
    step(1, 0, 1, 8'd4, 32'h44, 0, 8'd0);
    idle(1);
    rd(8'd70);
    idle(1);
    check("t4_addr_err_cnt", addr_err_cnt, 32'd1);
    check("t4_frame_cnt", frame_cnt, 32'd3);

    // Stray beat without sop.
    step(1, 0, 0, 8'd6, 32'h66, 0, 8'd0);
    rd(8'd6);
    idle(1);
    check("t5_frame_err_cnt", frame_err_cnt, 32'd2);

    // Reset mid-frame, then a new frame on the first cycle after release.
    step(1, 1, 0, 8'd2, 32'h99, 0, 8'd0);
    Rst_n = 1'b0;
    model_reset();
    idle(2);
    Rst_n = 1'b1;
    check("t6_frame_cnt_after_reset", frame_cnt, 32'd0);
    step(1, 1, 0, 8'd2, 32'h55, 1, 8'd2);
    step(1, 0, 1, 8'd7, 32'h77, 0, 8'd0);
    idle(2);
    rd(8'd2);
    idle(1);
    check("t6_frame_cnt", frame_cnt, 32'd1);

    // Randomized traffic with address collisions and concurrent reads.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a, ra;
      a  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 11));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
           a, $urandom, $urandom_range(0, 9) < 4, ra);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stats_unpacker_avlstrm.md
# stats_unpacker_avlstrm

Receive end of the stats stream emitted by the per-service stats packers. Consumes framed `{addr, val}` beats from an `avl_stream_if` and deposits each value into a register array indexed by `addr`. Serves the array to the host through a single-cycle CSR read port. Sits at top level between the services' `stats_out` streams (after any arbitration) and the CSR fabric.

## Interface
Parameters:
- `NUM_REGS`, default 64: number of stats registers held; valid addresses are 0..NUM_REGS-1.
- `REG_AWIDTH`, default 8: width of the beat address field and of `csr_address`.
- `VAL_WIDTH`, default 32: width of the value field and of `csr_readdata`.

Ports:
- `Clk` — in, 1: single clock for all logic.
- `Rst_n` — in, 1: reset, asynchronous, active-low.
- `in` — `avl_stream_if.rx`, WIDTH=REG_AWIDTH+VAL_WIDTH: stats beats. `data[REG_AWIDTH+VAL_WIDTH-1:VAL_WIDTH]`=addr, `data[VAL_WIDTH-1:0]`=val. `sop` marks the first beat of a frame, `eop` the last; `empty` is ignored.
- `csr_address` — in, REG_AWIDTH: register index to read.
- `csr_read` — in, 1: read strobe.
- `csr_readdata` — out, VAL_WIDTH: read data.
- `csr_readdatavalid` — out, 1: read data valid.
- `frame_cnt` — out, 32: frames completed.
- `frame_err_cnt` — out, 32: framing errors.
- `addr_err_cnt` — out, 32: beats dropped because the address is out of range.
- `update` — out, 1: one-cycle pulse when new values become visible to CSR reads.

## Operation
- A beat is accepted when `in.valid && in.ready`.
- FSM states: IDLE, FRAME, COMMIT.
- IDLE:
  - Accepted beat with sop=1, eop=0: process the beat, go to FRAME.
  - Accepted beat with sop=1, eop=1: process the beat, end the frame (see below).
  - Accepted beat with sop=0: drop it, increment `frame_err_cnt`, stay in IDLE.
- FRAME:
  - Accepted beat with sop=0: process it. If eop=1, end the frame.
  - Accepted beat with sop=1: this is a missing-eop error. Increment `frame_err_cnt`, discard the pending frame, then treat the beat as a fresh sop from IDLE.
- Processing a beat:
  - If addr < NUM_REGS, write val to the entry.
  - If addr ≥ NUM_REGS, drop the value and increment `addr_err_cnt`. Framing tracking is unaffected.
  - If two beats in one frame carry the same addr, the last one wins.
- Ending a frame: increment `frame_cnt`, then enter COMMIT (macro on) or IDLE (macro off).
- COMMIT (macro on only): `in.ready`=0. Copy every pending shadow entry to the visible array, clear the pending bits, pulse `update`, go to IDLE.
- `in.ready`=1 in every state except COMMIT.
- CSR read: when `csr_read`=1, register on the next edge `csr_readdata` = visible[csr_address], or 0 if csr_address ≥ NUM_REGS, and set `csr_readdatavalid`=1 for exactly one cycle.
- All three counters wrap modulo 2^32.

## Timing
- Reset values:
  - FSM = IDLE, `in.ready`=0 while Rst_n=0.
  - Visible array, shadow array and pending bits = 0.
  - `csr_readdata`=0, `csr_readdatavalid`=0, `update`=0, all counters = 0.
  - Reset asserted mid-frame discards the frame. No counter increments for it.
- CSR latency: 1 cycle, back-to-back reads allowed, no read stall.
- Write visibility, macro off: beat accepted at edge N. A read issued in cycle N+1 returns the new value.
- Write visibility, macro on: eop accepted at edge N, COMMIT during cycle N+1, copy and `update` pulse at edge N+1. A read issued in cycle N+2 returns the new value; a read in cycle N+1 returns the old value.
- Read colliding with a write or commit at the same edge returns the pre-update value.
- Macro off: `update` pulses one cycle after each accepted beat that writes an in-range entry.

## Configuration
- `STATS_UNPACK_COHERENT_EN`
  - Defined: beats write a shadow array with per-entry pending bits, and the COMMIT state applies the whole frame atomically. A frame discarded on an error never reaches the visible array.
  - Undefined: no shadow array and no COMMIT state. Beats write the visible array directly and `in.ready` is constant 1 after reset. Entries written before an error remain written.

## Test plan
- Frame of 3 beats {addr 2 val 0x10, addr 5 val 0x20, addr 2 val 0x30}, then read addr 2 and addr 5 → 0x30 and 0x20, `frame_cnt`=1, errors 0.
- Macro on, read addr 5 in the COMMIT cycle, then again one cycle later → old value 0, then 0x20. `in.ready`=0 for exactly one cycle.
- sop, addr 1 val 7; then sop again (no eop), addr 1 val 9, eop → `frame_err_cnt`=1, `frame_cnt`=1, addr 1 reads 9. Macro on: addr 1 never reads 7.
- Beat with addr 70 (NUM_REGS=64) inside a frame → `addr_err_cnt`=1, `frame_cnt` still increments. CSR read of addr 70 returns 0 with `csr_readdatavalid` high for 1 cycle.
- Stray beat with sop=0 in IDLE → dropped, `frame_err_cnt`=1, no array change.
- Assert Rst_n=0 mid-frame, release, read addr 2 → 0, all counters 0, FSM accepts a new sop on the first cycle after reset.
